cr_prefix_obc: RTL and testbench

- Output block controller for cr_prefix.
- Merges the bypass TLV stream (CMD, FRMD_USER_*, CQE/other) with the generated prefix-data (PFD) TLV stream and the data-path TLV stream, restoring frame order onto the user outbound interface.
- Sits between the bypass TLV FIFO, the PFD generator FIFO and the data FIFO on one side, and usr_ob on the other.
- Counterpart of the input block controller that splits the inbound stream.

---
 rtl/cr_prefix_obc_pkg.sv | 38 +++
 rtl/cr_prefix_obc_if.sv | 19 +
 rtl/cr_prefix_obc_oreg.sv | 24 ++
 rtl/cr_prefix_obc.sv | 93 +++++++++
 tb/tb_cr_prefix_obc.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cr_prefix_obc_pkg.sv
// cr_prefix_obc_pkg: shared TLV types, output-controller states and helpers for cr_prefix_obc
package cr_prefix_obc_pkg;

    localparam int PFD_MAX_WORDS_DEF = 64;

    typedef enum logic [1:0] {BP, PFD, DATA} obc_state_e;

    typedef enum logic [3:0] {
        RQE, CMD, FRMD_USER_NULL, FRMD_USER_PI16, FRMD_USER_PI64, FRMD_USER_VM,
        FRMD_INT, PFD_TLV, DATA_TLV, DATA_UNK, CQE
    } tlv_types_e;

    typedef enum logic [1:0] {NO_PREFIX, PREDEF_PREFIX, PREDET_HUFF, USER_PREFIX} xp10_prefix_mode_e;

    typedef struct packed {
        logic [47:0]       rsvd;
        logic [5:0]        xp10_user_prefix_size;
        xp10_prefix_mode_e xp10_prefix_mode;
        logic [7:0]        misc;
    } tlv_cmd_word_2_t;

    typedef struct packed {
        tlv_types_e  typen;
        logic        sot;
        logic        eot;
        logic [63:0] tdata;
    } tlvp_if_bus_t;

    function automatic logic is_frmd_user(tlv_types_e t);
        return t inside {FRMD_USER_NULL, FRMD_USER_PI16, FRMD_USER_PI64, FRMD_USER_VM};
    endfunction

    // A generated prefix is inserted only for built-in prefix modes with no user prefix
    function automatic logic prefix_gen_en(tlv_cmd_word_2_t c);
        return (c.xp10_user_prefix_size == '0) && (c.xp10_prefix_mode inside {PREDET_HUFF, PREDEF_PREFIX});
    endfunction

endpackage

// File: rtl/cr_prefix_obc_if.sv
// cr_prefix_obc_if: show-ahead FIFO read port and outbound write port used by cr_prefix_obc
interface cr_prefix_obc_if;
    import cr_prefix_obc_pkg::*;
    logic         empty;
    tlvp_if_bus_t tlv;
    logic         rd;
    modport master (input empty, input tlv, output rd);
    modport slave (output empty, output tlv, input rd);
endinterface

interface cr_prefix_obc_ob_if;
    import cr_prefix_obc_pkg::*;
    logic         full;
    logic         afull;
    logic         wr;
    tlvp_if_bus_t tlv;
    modport master (input full, input afull, output wr, output tlv);
    modport slave (output full, output afull, input wr, input tlv);
endinterface

// File: rtl/cr_prefix_obc_oreg.sv
// cr_prefix_obc_oreg: one-deep registered output stage driving the outbound word and strobe
module cr_prefix_obc_oreg
    import cr_prefix_obc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  tlvp_if_bus_t d,
    output logic         wr,
    output tlvp_if_bus_t q
);

    // Strobe follows the pop by one cycle; the word holds until the next pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr <= 1'b0;
            q  <= '0;
        end else begin
            wr <= ld;
            if (ld) q <= d;
        end
    end

endmodule

// File: rtl/cr_prefix_obc.sv
// cr_prefix_obc: merges bypass, prefix-data and data TLV streams back into frame order on usr_ob
module cr_prefix_obc
    import cr_prefix_obc_pkg::*;
#(
    parameter int PFD_MAX_WORDS = PFD_MAX_WORDS_DEF,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    cr_prefix_obc_if.master    bp,
    cr_prefix_obc_if.master    pfd,
    cr_prefix_obc_if.master    data,
    cr_prefix_obc_ob_if.master usr_ob,
    output logic [CNT_W-1:0]   obc_data_words,
    output logic               obc_err
);

    localparam int PW = $clog2(PFD_MAX_WORDS + 1);

    obc_state_e       state, state_nxt;
    logic             pfd_en, pfd_en_nxt;
    logic [PW-1:0]    pfd_cnt, pfd_cnt_nxt;
    logic [CNT_W-1:0] words_nxt;
    logic             err_nxt, stall, sel_empty, pop;
    tlvp_if_bus_t     head, fwd;

    // Source select, pop decision and next-state for the frame sequencer
    always_comb begin
        stall       = usr_ob.full | (usr_ob.afull & usr_ob.wr);
        head        = state == PFD ? pfd.tlv : state == DATA ? data.tlv : bp.tlv;
        sel_empty   = state == PFD ? pfd.empty : state == DATA ? data.empty : bp.empty;
        pop         = rst_n & ~stall & ~sel_empty;
        bp.rd       = pop & (state == BP);
        pfd.rd      = pop & (state == PFD);
        data.rd     = pop & (state == DATA);
        fwd         = head;
        state_nxt   = state;
        pfd_en_nxt  = pfd_en;
        pfd_cnt_nxt = pfd_cnt;
        words_nxt   = obc_data_words;
        err_nxt     = 1'b0;
        if (pop && state == BP) begin
            if (head.typen == CMD && head.eot) pfd_en_nxt = prefix_gen_en(tlv_cmd_word_2_t'(head.tdata));
            if (is_frmd_user(head.typen) && head.eot) begin
                state_nxt   = pfd_en ? PFD : DATA;
                pfd_cnt_nxt = '0;
            end
            err_nxt = head.typen == DATA_UNK;
        end else if (pop && state == PFD) begin
            pfd_cnt_nxt = pfd_cnt + 1'b1;
            if (head.eot) begin
                state_nxt = DATA;
            end else if (pfd_cnt_nxt == PW'(PFD_MAX_WORDS)) begin
                err_nxt   = 1'b1;
                fwd.eot   = 1'b1;
                state_nxt = DATA;
            end
        end else if (pop && state == DATA) begin
            words_nxt = head.sot ? CNT_W'(1) : (&obc_data_words ? obc_data_words : obc_data_words + 1'b1);
            if (head.eot) begin
                state_nxt  = BP;
                pfd_en_nxt = 1'b0;
            end
        end
    end

    // Sequencer state, prefix enable, counters and the error pulse aligned with the forwarded word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= BP;
            pfd_en         <= 1'b0;
            pfd_cnt        <= '0;
            obc_data_words <= '0;
            obc_err        <= 1'b0;
        end else begin
            state          <= state_nxt;
            pfd_en         <= pfd_en_nxt;
            pfd_cnt        <= pfd_cnt_nxt;
            obc_data_words <= words_nxt;
            obc_err        <= err_nxt;
        end
    end

    cr_prefix_obc_oreg u_oreg (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (pop),
        .d     (fwd),
        .wr    (usr_ob.wr),
        .q     (usr_ob.tlv)
    );

endmodule

// File: tb/tb_cr_prefix_obc.sv
// tb_cr_prefix_obc: randomized scoreboard bench for cr_prefix_obc against a frame-level stream model
module tb_cr_prefix_obc;
    import cr_prefix_obc_pkg::*;

    localparam int MAXW = 64;

    typedef struct packed {
        tlvp_if_bus_t w;
        logic         e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] words;
    logic        err;

    cr_prefix_obc_if    bp_if ();
    cr_prefix_obc_if    pfd_if ();
    cr_prefix_obc_if    data_if ();
    cr_prefix_obc_ob_if ob_if ();

    cr_prefix_obc dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bp             (bp_if),
        .pfd            (pfd_if),
        .data           (data_if),
        .usr_ob         (ob_if),
        .obc_data_words (words),
        .obc_err        (err)
    );

    always #5 clk = ~clk;

    tlvp_if_bus_t bp_q[$], pfd_q[$], data_q[$], held[$];
    tlvp_if_bus_t m_bp[$], m_pfd[$], m_data[$];
    exp_t         exp_q[$];
    int           compared = 0, mismatched = 0, wr_cnt = 0, err_cnt = 0, m_words = 0;
    bit           m_pfd_en = 1'b0, rand_bp = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic tlvp_if_bus_t mk(input tlv_types_e t, input bit s, input bit e, input logic [63:0] d);
        tlvp_if_bus_t w;
        w.typen = t;
        w.sot   = s;
        w.eot   = e;
        w.tdata = d;
        return w;
    endfunction

    task automatic refresh();
        bp_if.empty   = bp_q.size() == 0;
        bp_if.tlv     = bp_q.size() > 0 ? bp_q[0] : '0;
        pfd_if.empty  = pfd_q.size() == 0;
        pfd_if.tlv    = pfd_q.size() > 0 ? pfd_q[0] : '0;
        data_if.empty = data_q.size() == 0;
        data_if.tlv   = data_q.size() > 0 ? data_q[0] : '0;
    endtask

    task automatic step();
        logic b, p, d;
        @(negedge clk);
        b = bp_if.rd;
        p = pfd_if.rd;
        d = data_if.rd;
        @(posedge clk);
        #1;
        if (b && bp_q.size() > 0) void'(bp_q.pop_front());
        if (p && pfd_q.size() > 0) void'(pfd_q.pop_front());
        if (d && data_q.size() > 0) void'(data_q.pop_front());
        if (rand_bp) begin
            ob_if.full  = $urandom_range(0, 7) == 0;
            ob_if.afull = $urandom_range(0, 3) == 0;
        end
        refresh();
    endtask

    task automatic push_exp(input tlvp_if_bus_t w, input bit e);
        exp_t x;
        x.w = w;
        x.e = e;
        exp_q.push_back(x);
    endtask

    // Frame-level reference: walks the three streams in frame order
    task automatic model_run();
        tlvp_if_bus_t w, p, d;
        tlv_cmd_word_2_t c;
        int n;
        while (m_bp.size() > 0) begin
            w = m_bp.pop_front();
            push_exp(w, w.typen == DATA_UNK);
            if (w.typen == CMD && w.eot) begin
                c = tlv_cmd_word_2_t'(w.tdata);
                m_pfd_en = (c.xp10_user_prefix_size == 0) &&
                           (c.xp10_prefix_mode == PREDEF_PREFIX || c.xp10_prefix_mode == PREDET_HUFF);
            end
            if (w.eot && w.typen inside {FRMD_USER_NULL, FRMD_USER_PI16, FRMD_USER_PI64, FRMD_USER_VM}) begin
                n = 0;
                while (m_pfd_en && m_pfd.size() > 0) begin
                    p = m_pfd.pop_front();
                    n++;
                    if (!p.eot && n == MAXW) begin
                        p.eot = 1'b1;
                        push_exp(p, 1'b1);
                        break;
                    end
                    push_exp(p, 1'b0);
                    if (p.eot) break;
                end
                while (m_data.size() > 0) begin
                    d = m_data.pop_front();
                    m_words = d.sot ? 1 : (m_words < 65535 ? m_words + 1 : 65535);
                    push_exp(d, 1'b0);
                    if (d.eot) break;
                end
                m_pfd_en = 1'b0;
            end
        end
    endtask

    task automatic put_bp(input tlvp_if_bus_t w);
        bp_q.push_back(w);
        m_bp.push_back(w);
    endtask

    task automatic send_frame(input bit has_cmd, input int psz, input int mode, input int n_pfd,
                              input bit pfd_eot, input int n_data, input bit unk, input bit hold);
        tlvp_if_bus_t    w;
        tlv_cmd_word_2_t c;
        tlv_types_e      fr;
        if (unk) put_bp(mk(DATA_UNK, 1'b1, 1'b1, rnd64()));
        if (has_cmd) begin
            c = tlv_cmd_word_2_t'(rnd64());
            c.xp10_user_prefix_size = 6'(psz);
            c.xp10_prefix_mode = xp10_prefix_mode_e'(2'(mode));
            put_bp(mk(CMD, 1'b1, 1'b1, 64'(c)));
        end
        case ($urandom_range(0, 3))
            0: fr = FRMD_USER_NULL;
            1: fr = FRMD_USER_PI16;
            2: fr = FRMD_USER_PI64;
            default: fr = FRMD_USER_VM;
        endcase
        put_bp(mk(fr, 1'b1, 1'b1, rnd64()));
        for (int i = 0; i < n_pfd; i++) begin
            w = mk(PFD_TLV, i == 0, pfd_eot && i == n_pfd - 1, rnd64());
            m_pfd.push_back(w);
            if (hold) held.push_back(w);
            else pfd_q.push_back(w);
        end
        for (int i = 0; i < n_data; i++) begin
            w = mk(DATA_TLV, i == 0, i == n_data - 1, rnd64());
            m_data.push_back(w);
            data_q.push_back(w);
        end
        put_bp(mk(CQE, 1'b1, 1'b1, rnd64()));
        model_run();
        refresh();
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 5000) begin
            step();
            t++;
        end
        repeat (2) step();
        chk("drain_pending", 128'(exp_q.size()), 128'(0));
    endtask

    // Monitor: pops the scoreboard on every write and checks the pop rule every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            logic st, bad;
            int   n;
            st  = ob_if.full | (ob_if.afull & ob_if.wr);
            n   = int'(bp_if.rd) + int'(pfd_if.rd) + int'(data_if.rd);
            bad = (st && n > 0) || n > 1 || (bp_if.rd && bp_if.empty) ||
                  (pfd_if.rd && pfd_if.empty) || (data_if.rd && data_if.empty);
            chk("pop_rule", 128'(bad), 128'(0));
            if (err) err_cnt++;
            if (ob_if.wr) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: got %0h with nothing expected", ob_if.tlv);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_tlv", 128'(ob_if.tlv), 128'(e.w));
                    chk("out_err", 128'(err), 128'(e.e));
                end
            end else begin
                chk("err_idle", 128'(err), 128'(0));
            end
        end
    end

    initial begin
        int t, w0, e0, pre;
        ob_if.full  = 1'b0;
        ob_if.afull = 1'b0;
        refresh();
        repeat (3) step();
        chk("rst_wr", 128'(ob_if.wr), 128'(0));
        chk("rst_tlv", 128'(ob_if.tlv), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_words", 128'(words), 128'(0));
        chk("rst_rd", 128'({bp_if.rd, pfd_if.rd, data_if.rd}), 128'(0));
        rst_n = 1'b1;

        e0 = err_cnt;
        send_frame(1'b1, 0, int'(PREDEF_PREFIX), 3, 1'b1, 5, 1'b0, 1'b0);
        drain();
        chk("prefix_data_words", 128'(words), 128'(5));
        chk("prefix_no_err", 128'(err_cnt - e0), 128'(0));

        w0 = wr_cnt;
        send_frame(1'b1, 0, int'(PREDET_HUFF), 3, 1'b1, 5, 1'b0, 1'b1);
        repeat (25) step();
        chk("pfd_wait_data_untouched", 128'(data_q.size()), 128'(5));
        chk("pfd_wait_writes", 128'(wr_cnt - w0), 128'(2));
        while (held.size() > 0) pfd_q.push_back(held.pop_front());
        refresh();
        drain();
        chk("pfd_wait_data_words", 128'(words), 128'(5));

        e0 = err_cnt;
        send_frame(1'b1, 0, int'(PREDEF_PREFIX), 64, 1'b0, 3, 1'b0, 1'b0);
        drain();
        chk("runaway_err_pulses", 128'(err_cnt - e0), 128'(1));
        chk("runaway_data_words", 128'(words), 128'(3));

        ob_if.afull = 1'b1;
        send_frame(1'b1, 0, int'(PREDEF_PREFIX), 2, 1'b1, 6, 1'b0, 1'b0);
        drain();
        ob_if.afull = 1'b0;
        chk("afull_data_words", 128'(words), 128'(6));

        send_frame(1'b1, 4, int'(PREDEF_PREFIX), 0, 1'b1, 8, 1'b0, 1'b0);
        t = 0;
        while (data_q.size() > 5 && t < 500) begin
            step();
            t++;
        end
        chk("full_reach_data", 128'(t < 500), 128'(1));
        ob_if.full = 1'b1;
        step();
        w0 = wr_cnt;
        repeat (9) step();
        chk("full_hold_writes", 128'(wr_cnt - w0), 128'(0));
        ob_if.full = 1'b0;
        drain();
        chk("full_data_words", 128'(words), 128'(8));

        send_frame(1'b1, 0, int'(PREDEF_PREFIX), 2, 1'b1, 6, 1'b0, 1'b0);
        t = 0;
        while (data_q.size() > 4 && t < 500) begin
            step();
            t++;
        end
        chk("reset_reach_data", 128'(t < 500), 128'(1));
        rst_n = 1'b0;
        step();
        chk("midrst_wr", 128'(ob_if.wr), 128'(0));
        chk("midrst_tlv", 128'(ob_if.tlv), 128'(0));
        chk("midrst_err", 128'(err), 128'(0));
        chk("midrst_words", 128'(words), 128'(0));
        chk("midrst_rd", 128'({bp_if.rd, pfd_if.rd, data_if.rd}), 128'(0));
        bp_q.delete();
        pfd_q.delete();
        data_q.delete();
        m_bp.delete();
        m_pfd.delete();
        m_data.delete();
        exp_q.delete();
        m_pfd_en = 1'b0;
        m_words  = 0;
        refresh();
        rst_n = 1'b1;
        send_frame(1'b0, 0, 0, 2, 1'b1, 4, 1'b0, 1'b0);
        drain();
        chk("postrst_data_words", 128'(words), 128'(4));

        send_frame(1'b1, 4, int'(PREDEF_PREFIX), 2, 1'b1, 3, 1'b0, 1'b0);
        pre = pfd_q.size();
        drain();
        chk("bypass_pfd_untouched", 128'(pfd_q.size()), 128'(pre));
        chk("bypass_data_words", 128'(words), 128'(3));

        rand_bp = 1'b1;
        for (int b = 0; b < 10; b++) begin
            for (int f = 0; f < 4; f++)
                send_frame($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(1, 63)),
                           int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1'b1,
                           int'($urandom_range(1, 8)), $urandom_range(0, 9) == 0, 1'b0);
            drain();
        end
        rand_bp     = 1'b0;
        ob_if.full  = 1'b0;
        ob_if.afull = 1'b0;
        drain();
        chk("final_data_words", 128'(words), 128'(m_words));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
